// File: rtl/ae18_stkctl_pkg.sv
// Shared definitions for the AE18 return-stack controller: default sizes
// and the per-cycle command classification used by the controller.
package ae18_stkctl_pkg;

    localparam int ISIZ_DEF = 24;
    localparam int SSIZ_DEF = 5;
    localparam int MAX_DEF  = (1 << SSIZ_DEF) - 1;

    // One command class wins each cycle; reset is handled outside this decode.
    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_PTR  = 3'd1,   // pointer load, everything else ignored
        CMD_REPL = 3'd2,   // push and pop together: replace TOS
        CMD_PUSH = 3'd3,
        CMD_POP  = 3'd4,
        CMD_TOSW = 3'd5    // overwrite TOS, pointer unchanged
    } stk_cmd_e;

    function automatic stk_cmd_e stk_cmd_decode(
        input logic push,
        input logic pop,
        input logic tos_we,
        input logic ptr_we
    );
        stk_cmd_e cmd;
        cmd = CMD_NONE;
        if (ptr_we)             cmd = CMD_PTR;
        else if (push && pop)   cmd = CMD_REPL;
        else if (push)          cmd = CMD_PUSH;
        else if (pop)           cmd = CMD_POP;
        else if (tos_we)        cmd = CMD_TOSW;
        return cmd;
    endfunction

endpackage

// File: rtl/ae18_stkram.sv
// Stack storage: synchronous write port, registered read address and
// combinational data out, so a write and a read of the same entry in one
// cycle returns the new data on the following cycle.
module ae18_stkram #(
    parameter int AW = 5,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] raddr_reg;

    // Write port and read-address register.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        raddr_reg <= raddr;
    end

    assign rdata = mem[raddr_reg];

endmodule

// File: rtl/ae18_stkctl.sv
// AE18 return-stack controller: owns the stack pointer, the sticky
// overflow/underflow flags and the reset request, and is the only master
// of the stack RAM. tos follows the pointer one cycle after any command.
module ae18_stkctl
    import ae18_stkctl_pkg::*;
#(
    parameter int ISIZ   = ISIZ_DEF,
    parameter int SSIZ   = SSIZ_DEF,
    parameter bit STVREN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            tos_we,
    input  logic [ISIZ-1:0] wdat,
    input  logic            ptr_we,
    input  logic [SSIZ-1:0] ptr_wdat,
    input  logic            flg_clr,
    output logic [ISIZ-1:0] tos,
    output logic [SSIZ-1:0] stkptr,
    output logic            full,
    output logic            stkful,
    output logic            stkunf,
    output logic            rst_req
);

    localparam logic [SSIZ-1:0] MAX  = '1;
    localparam logic [SSIZ-1:0] ONE  = {{(SSIZ-1){1'b0}}, 1'b1};

    logic [SSIZ-1:0] stkptr_reg;
    logic [SSIZ-1:0] stkptr_next;
    logic            stkful_reg;
    logic            stkunf_reg;
    logic            rst_req_reg;
    logic            ovf_evt;
    logic            unf_evt;
    logic            ram_we;
    logic [SSIZ-1:0] ram_waddr;
    logic [ISIZ-1:0] ram_rdata;
    stk_cmd_e        cmd;

    assign cmd = stk_cmd_decode(push, pop, tos_we, ptr_we);

    // Next pointer, RAM write and flag events; pointer saturates at 0 and MAX.
    always_comb begin
        stkptr_next = stkptr_reg;
        ram_we      = 1'b0;
        ram_waddr   = stkptr_reg;
        ovf_evt     = 1'b0;
        unf_evt     = 1'b0;
        if (rst) begin
            stkptr_next = '0;
        end else begin
            case (cmd)
                CMD_PTR: stkptr_next = ptr_wdat;
                CMD_REPL: begin
                    if (stkptr_reg == '0) unf_evt = 1'b1;
                    else                  ram_we  = 1'b1;
                end
                CMD_PUSH: begin
                    if (stkptr_reg == MAX) begin
                        ovf_evt = 1'b1;
                    end else begin
                        ram_we      = 1'b1;
                        ram_waddr   = stkptr_reg + ONE;
                        stkptr_next = stkptr_reg + ONE;
                    end
                end
                CMD_POP: begin
                    if (stkptr_reg == '0) unf_evt     = 1'b1;
                    else                  stkptr_next = stkptr_reg - ONE;
                end
                CMD_TOSW: ram_we = (stkptr_reg != '0);
                default: ;
            endcase
        end
    end

    // Pointer, sticky flags and reset-request pulse; a flag set wins over flg_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            stkptr_reg  <= '0;
            stkful_reg  <= 1'b0;
            stkunf_reg  <= 1'b0;
            rst_req_reg <= 1'b0;
        end else begin
            stkptr_reg  <= stkptr_next;
            rst_req_reg <= STVREN && (ovf_evt || unf_evt);
            if (flg_clr && (cmd != CMD_PTR)) begin
                stkful_reg <= 1'b0;
                stkunf_reg <= 1'b0;
            end
            if (ovf_evt) stkful_reg <= 1'b1;
            if (unf_evt) stkunf_reg <= 1'b1;
        end
    end

    ae18_stkram #(
        .AW (SSIZ),
        .DW (ISIZ)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (wdat),
        .raddr (stkptr_next),
        .rdata (ram_rdata)
    );

    assign tos     = (stkptr_reg == '0) ? '0 : ram_rdata;
    assign stkptr  = stkptr_reg;
    assign full    = (stkptr_reg == MAX);
    assign stkful  = stkful_reg;
    assign stkunf  = stkunf_reg;
    assign rst_req = rst_req_reg;

endmodule

// File: tb/tb_ae18_stkctl.sv
// Bench for ae18_stkctl: directed scenarios followed by random command
// traffic, every cycle compared against a behavioural stack model.
module tb_ae18_stkctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        tos_we = 1'b0;
    logic [23:0] wdat = '0;
    logic        ptr_we = 1'b0;
    logic [4:0]  ptr_wdat = '0;
    logic        flg_clr = 1'b0;
    logic [23:0] tos;
    logic [4:0]  stkptr;
    logic        full;
    logic        stkful;
    logic        stkunf;
    logic        rst_req;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int        m_sp = 0;
    bit        m_ful = 0;
    bit        m_unf = 0;
    bit        m_req = 0;
    int        m_mem [32];
    bit        m_known [32];

    always #5 clk = ~clk;

    ae18_stkctl #(.ISIZ(24), .SSIZ(5), .STVREN(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .tos_we   (tos_we),
        .wdat     (wdat),
        .ptr_we   (ptr_we),
        .ptr_wdat (ptr_wdat),
        .flg_clr  (flg_clr),
        .tos      (tos),
        .stkptr   (stkptr),
        .full     (full),
        .stkful   (stkful),
        .stkunf   (stkunf),
        .rst_req  (rst_req)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behaviour of one cycle, straight from the stack rules.
    task automatic model(input bit r, input bit pu, input bit po, input bit tw,
                         input bit pw, input int pd, input bit fc, input int d);
        bit ovf, un;
        ovf = 0;
        un  = 0;
        if (r) begin
            m_sp = 0; m_ful = 0; m_unf = 0; m_req = 0;
            return;
        end
        if (pw) begin
            m_sp  = pd;
            m_req = 0;
            return;
        end
        if (pu && po) begin
            if (m_sp == 0) un = 1;
            else begin m_mem[m_sp] = d; m_known[m_sp] = 1; end
        end else if (pu) begin
            if (m_sp == 31) ovf = 1;
            else begin m_sp++; m_mem[m_sp] = d; m_known[m_sp] = 1; end
        end else if (po) begin
            if (m_sp == 0) un = 1;
            else m_sp--;
        end else if (tw) begin
            if (m_sp > 0) begin m_mem[m_sp] = d; m_known[m_sp] = 1; end
        end
        if (fc) begin m_ful = 0; m_unf = 0; end
        if (ovf) m_ful = 1;
        if (un)  m_unf = 1;
        m_req = ovf | un;
    endtask

    task automatic step(input bit r, input bit pu, input bit po, input bit tw,
                        input bit pw, input int pd, input bit fc, input int d);
        rst = r; push = pu; pop = po; tos_we = tw;
        ptr_we = pw; ptr_wdat = pd[4:0]; flg_clr = fc; wdat = d[23:0];
        @(posedge clk);
        model(r, pu, po, tw, pw, pd, fc, d);
        #1;
        $display("cyc rst=%0b push=%0b pop=%0b tos_we=%0b ptr_we=%0b/%0d clr=%0b wdat=%h -> sp=%0d tos=%h ful=%0b unf=%0b req=%0b",
                 r, pu, po, tw, pw, pd, fc, d[23:0], stkptr, tos, stkful, stkunf, rst_req);
        check("stkptr",  32'(stkptr),  32'(m_sp));
        check("full",    32'(full),    32'(m_sp == 31));
        check("stkful",  32'(stkful),  32'(m_ful));
        check("stkunf",  32'(stkunf),  32'(m_unf));
        check("rst_req", 32'(rst_req), 32'(m_req));
        if (m_sp == 0)               check("tos", 32'(tos), 32'h0);
        else if (m_known[m_sp])      check("tos", 32'(tos), m_mem[m_sp] & 32'hFFFFFF);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m_mem[i] = 0; m_known[i] = 0; end

        // reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // basic push/push/pop
        step(0, 1, 0, 0, 0, 0, 0, 24'h000100);
        step(0, 1, 0, 0, 0, 0, 0, 24'h000200);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        // fill to MAX then overflow twice
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 31; i++) step(0, 1, 0, 0, 0, 0, 0, i);
        step(0, 1, 0, 0, 0, 0, 0, 32);
        step(0, 1, 0, 0, 0, 0, 0, 33);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // underflow then flag clear
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        // TOS replace at depth 3, verify lower entries via pops
        step(0, 1, 0, 0, 0, 0, 0, 24'h000011);
        step(0, 1, 0, 0, 0, 0, 0, 24'h000022);
        step(0, 1, 0, 0, 0, 0, 0, 24'h000033);
        step(0, 1, 1, 0, 0, 0, 0, 24'hABCDEF);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        // pointer load beats push; then tos_we
        step(0, 1, 0, 0, 0, 0, 0, 24'h0000A1);
        step(0, 1, 0, 0, 0, 0, 0, 24'h0000B2);
        step(0, 1, 0, 0, 0, 0, 0, 24'h0000C3);
        step(0, 1, 0, 0, 1, 2, 0, 24'h999999);
        step(0, 0, 0, 1, 0, 0, 0, 24'h123456);
        step(0, 0, 0, 0, 1, 3, 0, 0);
        // reset during push at depth 5 leaves entry 6 intact
        step(0, 0, 0, 0, 1, 5, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 24'h666666);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 24'h777777);
        step(0, 0, 0, 0, 1, 6, 0, 0);
        // tos_we at pointer 0 is ignored
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 24'h555555);

        // random traffic, alternating push-heavy and pop-heavy phases
        for (int n = 0; n < 800; n++) begin
            bit r, pu, po, tw, pw, fc;
            int bias;
            bias = ((n / 60) % 2 == 0) ? 75 : 25;
            r  = ($urandom_range(0, 99) < 2);
            pw = ($urandom_range(0, 99) < 4);
            pu = ($urandom_range(0, 99) < bias);
            po = ($urandom_range(0, 99) < (100 - bias));
            tw = ($urandom_range(0, 99) < 15);
            fc = !pw && ($urandom_range(0, 99) < 8);
            step(r, pu, po, tw, pw, int'($urandom_range(0, 31)), fc,
                 int'($urandom_range(0, 24'hFFFFFF)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ae18_stkctl.md
# ae18_stkctl

Hardware return-stack controller for the AE18 core. Sits between the core's CALL/RETURN/interrupt sequencing and a 2^SSIZ x ISIZ synchronous RAM, acting as the RAM's sole writer and reader. It maintains the stack pointer, presents top-of-stack (TOS), and raises PIC18-style sticky full/underflow flags with an optional reset request.

## Interface
- ISIZ, 24: stack word width (return address).
- SSIZ, 5: pointer width; usable depth MAX = 2^SSIZ-1 (31); entry 0 never holds data.
- STVREN, 1: 1 = overflow/underflow events pulse rst_req.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  push wdat.
- pop  in  1  discard TOS.
- tos_we  in  1  overwrite TOS with wdat, pointer unchanged.
- wdat  in  ISIZ  data for push/tos_we.
- ptr_we  in  1  load pointer from ptr_wdat.
- ptr_wdat  in  SSIZ  new pointer value.
- flg_clr  in  1  clear stkful/stkunf.
- tos  out  ISIZ  current top of stack; 0 when stkptr==0.
- stkptr  out  SSIZ  current pointer (0 = empty).
- full  out  1  stkptr==MAX (combinational from pointer).
- stkful  out  1  sticky overflow flag.
- stkunf  out  1  sticky underflow flag.
- rst_req  out  1  one-cycle pulse on overflow/underflow when STVREN=1.

## Operation
- Command priority per cycle: rst > ptr_we > push/pop > tos_we > flg_clr (flag set beats flg_clr in the same cycle).
- push only, stkptr<MAX: RAM[stkptr+1] <= wdat; stkptr <= stkptr+1.
- push only, stkptr==MAX: no write, pointer held, stkful <= 1, rst_req pulse if STVREN.
- pop only, stkptr>0: stkptr <= stkptr-1; RAM untouched.
- pop only, stkptr==0: pointer held at 0, stkunf <= 1, rst_req pulse if STVREN.
- push and pop together: TOS replace, RAM[stkptr] <= wdat, pointer unchanged; if stkptr==0 treated as underflow, no write.
- tos_we: RAM[stkptr] <= wdat if stkptr>0; ignored at 0 (no flag).
- ptr_we: stkptr <= ptr_wdat; all other commands that cycle ignored; value MAX+1 impossible by width, so no wrap case.
- Pointer arithmetic is SSIZ bits, saturating by the rules above; never wraps 0<->MAX.
- RAM read address is driven with the next pointer value each cycle, so tos tracks stkptr.

## Timing
- Reset values: stkptr=0, stkful=0, stkunf=0, rst_req=0, tos=0, full=0. RAM contents not cleared.
- rst asserted with any command: command ignored, no RAM write.
- Pointer, flags, rst_req update on the edge the command is sampled; stkptr visible next cycle.
- tos valid the cycle after any push/pop/tos_we/ptr_we (registered RAM read address, read-after-write of same entry returns new data).
- Back-to-back commands every cycle supported; no stall, no busy output.
- rst_req high for exactly one cycle per offending command; repeated offending commands pulse each cycle.

## Structure
- Shared package: SSIZ/ISIZ defaults, MAX constant, command-priority encoding if enumerated.
- One sub-module: ae18_stkram, 2^SSIZ x ISIZ, synchronous write port, registered read address with combinational data out; controller owns all pointer/flag logic.

## Test plan
- Reset then push 0x000100, 0x000200 -> stkptr=2, tos=0x000200 next cycle; pop -> stkptr=1, tos=0x000100.
- 31 pushes of i -> full=1, stkptr=31, tos=31; 32nd push -> stkful=1, rst_req one-cycle pulse, tos still 31.
- pop at stkptr=0 -> stkunf=1, rst_req pulse, stkptr=0, tos=0; flg_clr -> both flags 0.
- stkptr=3, push+pop with wdat=0xABCDEF -> stkptr=3, tos=0xABCDEF; entries 1-2 unchanged (verify via pops).
- ptr_we=1, ptr_wdat=2 with push asserted -> stkptr=2, no RAM write; tos_we 0x123456 -> tos=0x123456.
- rst asserted during push at stkptr=5 -> stkptr=0, flags 0, RAM[6] unchanged.
